// File: rtl/mem_request_arbiter.sv
// Arbitrates one pending fetch, load and store onto a single-outstanding memory controller port,
// store first, with a counter that promotes a repeatedly passed-over fetch.
module mem_request_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_buffer_full,
  input  logic        rob_rollback_in,
  input  logic        fet_request_in,
  input  logic [31:0] fet_address_in,
  output logic        fet_ready_out,
  output logic [31:0] fet_instruction_out,
  input  logic        lsb_request_in,
  input  logic        lsb_rw_signal_in,
  input  logic [31:0] lsb_address_in,
  input  logic [2:0]  lsb_goal_in,
  input  logic [31:0] lsb_data_in,
  output logic        lsb_ready_out,
  output logic [31:0] lsb_data_out,
  output logic        mc_request_out,
  output logic        mc_rw_out,
  output logic [31:0] mc_address_out,
  output logic [2:0]  mc_goal_out,
  output logic [31:0] mc_data_out,
  input  logic        mc_ready_in,
  input  logic [31:0] mc_data_in
);

  localparam logic [2:0] SkipMax = 3'(STARVE_LIMIT);

  typedef enum logic {StIdle, StWait} state_e;
  typedef enum logic [1:0] {OwnFetch, OwnLoad, OwnStore} owner_e;
  typedef enum logic [1:0] {GntNone, GntFetch, GntLoad, GntStore} grant_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;

  logic        fet_pend_q, fet_pend_d;
  logic [31:0] fet_addr_q, fet_addr_d;
  logic        ld_pend_q, ld_pend_d;
  logic [31:0] ld_addr_q, ld_addr_d;
  logic [2:0]  ld_goal_q, ld_goal_d;
  logic        st_pend_q, st_pend_d;
  logic [31:0] st_addr_q, st_addr_d;
  logic [2:0]  st_goal_q, st_goal_d;
  logic [31:0] st_data_q, st_data_d;
  logic [2:0]  skip_q, skip_d;

  logic        mc_req_q, mc_req_d;
  logic        mc_rw_q, mc_rw_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [2:0]  mc_goal_q, mc_goal_d;
  logic [31:0] mc_wdata_q, mc_wdata_d;
  logic        fet_rdy_q, fet_rdy_d;
  logic [31:0] fet_instr_q, fet_instr_d;
  logic        lsb_rdy_q, lsb_rdy_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  logic   fet_ok, ld_ok, st_ok;
  logic   fet_busy, ld_busy, st_busy;
  grant_e grant;

  // Fetch and load are speculative, so a rollback makes them ineligible in the same cycle.
  always_comb begin
    fet_ok = fet_pend_q & ~rob_rollback_in;
    ld_ok  = ld_pend_q & ~rob_rollback_in;
    st_ok  = st_pend_q & ~(io_buffer_full & (st_addr_q[17:16] == 2'b11));
    grant  = GntNone;
    if (state_q == StIdle) begin
      if (fet_ok && (skip_q == SkipMax)) begin
        grant = GntFetch;
      end else if (st_ok) begin
        grant = GntStore;
      end else if (ld_ok) begin
        grant = GntLoad;
      end else if (fet_ok) begin
        grant = GntFetch;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    fet_pend_d  = fet_pend_q;
    fet_addr_d  = fet_addr_q;
    ld_pend_d   = ld_pend_q;
    ld_addr_d   = ld_addr_q;
    ld_goal_d   = ld_goal_q;
    st_pend_d   = st_pend_q;
    st_addr_d   = st_addr_q;
    st_goal_d   = st_goal_q;
    st_data_d   = st_data_q;
    skip_d      = skip_q;
    mc_req_d    = 1'b0;
    mc_rw_d     = mc_rw_q;
    mc_addr_d   = mc_addr_q;
    mc_goal_d   = mc_goal_q;
    mc_wdata_d  = mc_wdata_q;
    fet_rdy_d   = 1'b0;
    fet_instr_d = fet_instr_q;
    lsb_rdy_d   = 1'b0;
    lsb_rdata_d = lsb_rdata_q;

    fet_busy = fet_pend_q | ((state_q == StWait) && (owner_q == OwnFetch));
    ld_busy  = ld_pend_q | ((state_q == StWait) && (owner_q == OwnLoad));
    st_busy  = st_pend_q | ((state_q == StWait) && (owner_q == OwnStore));

    case (state_q)
      StIdle: begin
        if (grant != GntNone) state_d = StWait;
      end
      StWait: begin
        if (rob_rollback_in && (owner_q != OwnStore)) begin
          state_d = StIdle;
        end else if (mc_ready_in) begin
          state_d = StIdle;
          if (owner_q == OwnFetch) begin
            fet_rdy_d   = 1'b1;
            fet_instr_d = mc_data_in;
          end else begin
            lsb_rdy_d   = 1'b1;
            lsb_rdata_d = mc_data_in;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    case (grant)
      GntFetch: begin
        fet_pend_d = 1'b0;
        owner_d    = OwnFetch;
        mc_req_d   = 1'b1;
        mc_rw_d    = 1'b0;
        mc_addr_d  = fet_addr_q;
        mc_goal_d  = 3'd4;
        mc_wdata_d = '0;
        skip_d     = '0;
      end
      GntLoad: begin
        ld_pend_d  = 1'b0;
        owner_d    = OwnLoad;
        mc_req_d   = 1'b1;
        mc_rw_d    = 1'b0;
        mc_addr_d  = ld_addr_q;
        mc_goal_d  = ld_goal_q;
        mc_wdata_d = '0;
      end
      GntStore: begin
        st_pend_d  = 1'b0;
        owner_d    = OwnStore;
        mc_req_d   = 1'b1;
        mc_rw_d    = 1'b1;
        mc_addr_d  = st_addr_q;
        mc_goal_d  = st_goal_q;
        mc_wdata_d = st_data_q;
      end
      default: ;
    endcase

    if (((grant == GntLoad) || (grant == GntStore)) && fet_ok && (skip_q != SkipMax)) begin
      skip_d = skip_q + 3'd1;
    end

    if (rob_rollback_in) begin
      fet_pend_d = 1'b0;
      ld_pend_d  = 1'b0;
    end

    // Intake only fills empty slots, so it never collides with a grant clearing the same slot.
    if (fet_request_in && !fet_busy && !rob_rollback_in) begin
      fet_pend_d = 1'b1;
      fet_addr_d = fet_address_in;
    end
    if (lsb_request_in && lsb_rw_signal_in && !st_busy) begin
      st_pend_d = 1'b1;
      st_addr_d = lsb_address_in;
      st_goal_d = lsb_goal_in;
      st_data_d = lsb_data_in;
    end
    if (lsb_request_in && !lsb_rw_signal_in && !ld_busy && !rob_rollback_in) begin
      ld_pend_d = 1'b1;
      ld_addr_d = lsb_address_in;
      ld_goal_d = lsb_goal_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnFetch;
      fet_pend_q  <= 1'b0;
      fet_addr_q  <= '0;
      ld_pend_q   <= 1'b0;
      ld_addr_q   <= '0;
      ld_goal_q   <= '0;
      st_pend_q   <= 1'b0;
      st_addr_q   <= '0;
      st_goal_q   <= '0;
      st_data_q   <= '0;
      skip_q      <= '0;
      mc_req_q    <= 1'b0;
      mc_rw_q     <= 1'b0;
      mc_addr_q   <= '0;
      mc_goal_q   <= '0;
      mc_wdata_q  <= '0;
      fet_rdy_q   <= 1'b0;
      fet_instr_q <= '0;
      lsb_rdy_q   <= 1'b0;
      lsb_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      fet_pend_q  <= fet_pend_d;
      fet_addr_q  <= fet_addr_d;
      ld_pend_q   <= ld_pend_d;
      ld_addr_q   <= ld_addr_d;
      ld_goal_q   <= ld_goal_d;
      st_pend_q   <= st_pend_d;
      st_addr_q   <= st_addr_d;
      st_goal_q   <= st_goal_d;
      st_data_q   <= st_data_d;
      skip_q      <= skip_d;
      mc_req_q    <= mc_req_d;
      mc_rw_q     <= mc_rw_d;
      mc_addr_q   <= mc_addr_d;
      mc_goal_q   <= mc_goal_d;
      mc_wdata_q  <= mc_wdata_d;
      fet_rdy_q   <= fet_rdy_d;
      fet_instr_q <= fet_instr_d;
      lsb_rdy_q   <= lsb_rdy_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mc_request_out      = mc_req_q;
  assign mc_rw_out           = mc_rw_q;
  assign mc_address_out      = mc_addr_q;
  assign mc_goal_out         = mc_goal_q;
  assign mc_data_out         = mc_wdata_q;
  assign fet_ready_out       = fet_rdy_q;
  assign fet_instruction_out = fet_instr_q;
  assign lsb_ready_out       = lsb_rdy_q;
  assign lsb_data_out        = lsb_rdata_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter: per-cycle comparison against a transaction-level model plus
// directed scenarios with literal expectations.
module tb_mem_request_arbiter;

  localparam int LIMIT = 4;
  localparam int CF = 0;
  localparam int CL = 1;
  localparam int CS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_buffer_full = 1'b0;
  logic        rob_rollback_in = 1'b0;
  logic        fet_request_in = 1'b0;
  logic [31:0] fet_address_in = '0;
  logic        fet_ready_out;
  logic [31:0] fet_instruction_out;
  logic        lsb_request_in = 1'b0;
  logic        lsb_rw_signal_in = 1'b0;
  logic [31:0] lsb_address_in = '0;
  logic [2:0]  lsb_goal_in = '0;
  logic [31:0] lsb_data_in = '0;
  logic        lsb_ready_out;
  logic [31:0] lsb_data_out;
  logic        mc_request_out;
  logic        mc_rw_out;
  logic [31:0] mc_address_out;
  logic [2:0]  mc_goal_out;
  logic [31:0] mc_data_out;
  logic        mc_ready_in = 1'b0;
  logic [31:0] mc_data_in = '0;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  mem_request_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .io_buffer_full      (io_buffer_full),
    .rob_rollback_in     (rob_rollback_in),
    .fet_request_in      (fet_request_in),
    .fet_address_in      (fet_address_in),
    .fet_ready_out       (fet_ready_out),
    .fet_instruction_out (fet_instruction_out),
    .lsb_request_in      (lsb_request_in),
    .lsb_rw_signal_in    (lsb_rw_signal_in),
    .lsb_address_in      (lsb_address_in),
    .lsb_goal_in         (lsb_goal_in),
    .lsb_data_in         (lsb_data_in),
    .lsb_ready_out       (lsb_ready_out),
    .lsb_data_out        (lsb_data_out),
    .mc_request_out      (mc_request_out),
    .mc_rw_out           (mc_rw_out),
    .mc_address_out      (mc_address_out),
    .mc_goal_out         (mc_goal_out),
    .mc_data_out         (mc_data_out),
    .mc_ready_in         (mc_ready_in),
    .mc_data_in          (mc_data_in)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: one slot per class (index = class), owner of the memory port (-1 = free).
  logic        m_pend [3];
  logic [31:0] m_addr [3];
  logic [2:0]  m_goal [3];
  logic [31:0] m_data [3];
  int          m_owner;
  int          m_skip;
  logic        e_req, e_rw, e_fr, e_lr, e_lload;
  logic [31:0] e_addr, e_data, e_fi, e_ld;
  logic [2:0]  e_goal;

  always @(posedge clk) begin : model
    int   g;
    int   acc;
    logic cand [3];
    logic np [3];
    if (rst) begin
      for (int c = 0; c < 3; c++) m_pend[c] <= 1'b0;
      m_owner <= -1;
      m_skip  <= 0;
      e_req   <= 1'b0;
      e_fr    <= 1'b0;
      e_lr    <= 1'b0;
      e_lload <= 1'b0;
    end else begin
      cand[CF] = m_pend[CF] && !rob_rollback_in;
      cand[CL] = m_pend[CL] && !rob_rollback_in;
      cand[CS] = m_pend[CS] && !(io_buffer_full && (m_addr[CS][17:16] == 2'b11));
      g = -1;
      if (m_owner == -1) begin
        if (cand[CF] && m_skip == LIMIT) g = CF;
        // Store, then load, then fetch: descending class index.
        for (int c = 2; c >= 0; c--) if (g == -1 && cand[c]) g = c;
      end
      e_req <= (g != -1);
      if (g != -1) begin
        e_addr <= m_addr[g];
        e_rw   <= (g == CS);
        e_goal <= (g == CF) ? 3'd4 : m_goal[g];
        e_data <= m_data[g];
      end
      if (g == CF) m_skip <= 0;
      else if (g != -1 && cand[CF]) m_skip <= (m_skip < LIMIT) ? m_skip + 1 : LIMIT;
      e_fr <= 1'b0;
      e_lr <= 1'b0;
      if (g != -1) begin
        m_owner <= g;
      end else if (m_owner != -1) begin
        if (rob_rollback_in && m_owner != CS) begin
          m_owner <= -1;
        end else if (mc_ready_in) begin
          m_owner <= -1;
          if (m_owner == CF) begin
            e_fr <= 1'b1;
            e_fi <= mc_data_in;
          end else begin
            e_lr    <= 1'b1;
            e_lload <= (m_owner == CL);
            e_ld    <= mc_data_in;
          end
        end
      end
      for (int c = 0; c < 3; c++) np[c] = m_pend[c] && (g != c) && !(rob_rollback_in && c != CS);
      if (fet_request_in && !m_pend[CF] && m_owner != CF && !rob_rollback_in) begin
        np[CF] = 1'b1;
        m_addr[CF] <= fet_address_in;
      end
      acc = lsb_rw_signal_in ? CS : CL;
      if (lsb_request_in && !m_pend[acc] && m_owner != acc && !(rob_rollback_in && acc == CL)) begin
        np[acc] = 1'b1;
        m_addr[acc] <= lsb_address_in;
        m_goal[acc] <= lsb_goal_in;
        m_data[acc] <= lsb_data_in;
      end
      for (int c = 0; c < 3; c++) m_pend[c] <= np[c];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mc_request_out", 32'(mc_request_out), 32'(e_req));
      if (e_req) begin
        chk("mc_address_out", mc_address_out, e_addr);
        chk("mc_rw_out", 32'(mc_rw_out), 32'(e_rw));
        chk("mc_goal_out", 32'(mc_goal_out), 32'(e_goal));
        if (e_rw) chk("mc_data_out", mc_data_out, e_data);
      end
      chk("fet_ready_out", 32'(fet_ready_out), 32'(e_fr));
      if (e_fr) chk("fet_instruction_out", fet_instruction_out, e_fi);
      chk("lsb_ready_out", 32'(lsb_ready_out), 32'(e_lr));
      if (e_lr && e_lload) chk("lsb_data_out", lsb_data_out, e_ld);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lsb_set(input logic rw, input logic [31:0] a, input logic [31:0] d);
    lsb_request_in   = 1'b1;
    lsb_rw_signal_in = rw;
    lsb_address_in   = a;
    lsb_goal_in      = 3'd4;
    lsb_data_in      = d;
  endtask

  task automatic clear_req();
    fet_request_in = 1'b0;
    lsb_request_in = 1'b0;
  endtask

  task automatic wait_req(output logic [31:0] a, output logic rw);
    int ok;
    ok = 0;
    a  = '0;
    rw = 1'b0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      if (mc_request_out) begin
        ok = 1;
        a  = mc_address_out;
        rw = mc_rw_out;
      end else begin
        tick();
      end
    end
    if (ok == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_req: no mc_request_out within 40 cycles, required one");
    end
  endtask

  // Answer the outstanding request one cycle after it appears; returns in the ready-pulse cycle.
  task automatic serve(input logic [31:0] d);
    tick();
    mc_ready_in = 1'b1;
    mc_data_in  = d;
    tick();
    mc_ready_in = 1'b0;
  endtask

  function automatic int cls_of(input logic [31:0] a, input logic rw);
    if (rw) return CS;
    return (a >= 32'h1000) ? CF : CL;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mc_request"}, 32'(mc_request_out), 32'd0);
    chk({tag, "_mc_rw"}, 32'(mc_rw_out), 32'd0);
    chk({tag, "_mc_address"}, mc_address_out, 32'd0);
    chk({tag, "_mc_goal"}, 32'(mc_goal_out), 32'd0);
    chk({tag, "_mc_data"}, mc_data_out, 32'd0);
    chk({tag, "_fet_ready"}, 32'(fet_ready_out), 32'd0);
    chk({tag, "_fet_instr"}, fet_instruction_out, 32'd0);
    chk({tag, "_lsb_ready"}, 32'(lsb_ready_out), 32'd0);
    chk({tag, "_lsb_data"}, lsb_data_out, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic        rw;
    int          cls;
    int          st_left;
    int          ld_left;
    logic [31:0] t2_addr [3];
    logic        t2_rw [3];
    int          t3_seq [7];
    t2_addr = '{32'h200, 32'h100, 32'h2000};
    t2_rw   = '{1'b1, 1'b0, 1'b0};
    t3_seq  = '{CS, CL, CS, CL, CF, CS, CL};

    repeat (3) tick();
    rst = 1'b0;
    chk_all_zero("reset");
    cmp_en = 1'b1;

    // Lone fetch: request two cycles after the pulse, ready one cycle after mc_ready_in.
    fet_request_in = 1'b1;
    fet_address_in = 32'h0000_1000;
    tick();
    clear_req();
    chk("t1_req_t1", 32'(mc_request_out), 32'd0);
    tick();
    chk("t1_req_t2", 32'(mc_request_out), 32'd1);
    chk("t1_addr", mc_address_out, 32'h0000_1000);
    chk("t1_goal", 32'(mc_goal_out), 32'd4);
    chk("t1_rw", 32'(mc_rw_out), 32'd0);
    tick();
    chk("t1_req_pulse", 32'(mc_request_out), 32'd0);
    mc_ready_in = 1'b1;
    mc_data_in  = 32'h0000_0013;
    tick();
    mc_ready_in = 1'b0;
    chk("t1_fet_ready", 32'(fet_ready_out), 32'd1);
    chk("t1_instr", fet_instruction_out, 32'h0000_0013);
    tick();
    chk("t1_fet_ready_clr", 32'(fet_ready_out), 32'd0);

    // Priority: store, then load, then fetch.
    fet_request_in = 1'b1;
    fet_address_in = 32'h2000;
    lsb_set(1'b1, 32'h200, 32'hAAAA_5555);
    tick();
    fet_request_in = 1'b0;
    lsb_set(1'b0, 32'h100, 32'h0);
    tick();
    clear_req();
    for (int k = 0; k < 3; k++) begin
      wait_req(a, rw);
      chk($sformatf("t2_addr%0d", k), a, t2_addr[k]);
      chk($sformatf("t2_rw%0d", k), 32'(rw), 32'(t2_rw[k]));
      serve(32'h0BAD_F000 + 32'(k));
    end

    // Starvation: fetch wins after four load/store grants.
    fet_request_in = 1'b1;
    fet_address_in = 32'h3000;
    lsb_set(1'b1, 32'h204, 32'h5555_0000);
    tick();
    fet_request_in = 1'b0;
    lsb_set(1'b0, 32'h104, 32'h0);
    tick();
    clear_req();
    st_left = 2;
    ld_left = 2;
    for (int k = 0; k < 7; k++) begin
      wait_req(a, rw);
      cls = cls_of(a, rw);
      chk($sformatf("t3_grant%0d", k), 32'(cls), 32'(t3_seq[k]));
      serve(32'h100 + 32'(k));
      if (cls == CS && st_left > 0) begin
        st_left--;
        lsb_set(1'b1, 32'h208 + 32'(4 * st_left), 32'h5555_0001 + 32'(st_left));
        tick();
        clear_req();
      end else if (cls == CL && ld_left > 0) begin
        ld_left--;
        lsb_set(1'b0, 32'h108 + 32'(4 * ld_left), 32'h0);
        tick();
        clear_req();
      end
    end

    // IO store blocked by a full buffer must not block a load.
    io_buffer_full = 1'b1;
    lsb_set(1'b1, 32'h0003_0000, 32'h1234_5678);
    tick();
    lsb_set(1'b0, 32'h108, 32'h0);
    tick();
    clear_req();
    wait_req(a, rw);
    chk("t4_load_first", a, 32'h108);
    serve(32'h0000_0042);
    chk("t4_load_data", lsb_data_out, 32'h0000_0042);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_store_held%0d", k), 32'(mc_request_out), 32'd0);
      tick();
    end
    io_buffer_full = 1'b0;
    tick();
    chk("t4_store_req", 32'(mc_request_out), 32'd1);
    chk("t4_store_addr", mc_address_out, 32'h0003_0000);
    chk("t4_store_data", mc_data_out, 32'h1234_5678);
    serve(32'h0);

    // Rollback aborts an in-flight load, flushes a pending fetch, keeps the pending store.
    lsb_set(1'b0, 32'h10C, 32'h0);
    tick();
    clear_req();
    wait_req(a, rw);
    chk("t5_load_req", a, 32'h10C);
    lsb_set(1'b1, 32'h20C, 32'hCAFE_0001);
    fet_request_in = 1'b1;
    fet_address_in = 32'h4000;
    tick();
    clear_req();
    rob_rollback_in = 1'b1;
    tick();
    rob_rollback_in = 1'b0;
    chk("t5_no_lsb_ready", 32'(lsb_ready_out), 32'd0);
    mc_ready_in = 1'b1;
    mc_data_in  = 32'hDEAD_0000;
    tick();
    mc_ready_in = 1'b0;
    chk("t5_no_lsb_ready2", 32'(lsb_ready_out), 32'd0);
    chk("t5_store_req", 32'(mc_request_out), 32'd1);
    chk("t5_store_addr", mc_address_out, 32'h20C);
    chk("t5_store_rw", 32'(mc_rw_out), 32'd1);
    serve(32'h0);
    chk("t5_store_ready", 32'(lsb_ready_out), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t5_fetch_flushed%0d", k), 32'(mc_request_out), 32'd0);
    end

    // Reset mid-WAIT; the late memory response must be ignored.
    fet_request_in = 1'b1;
    fet_address_in = 32'h5000;
    tick();
    clear_req();
    wait_req(a, rw);
    chk("t6_fetch_req", a, 32'h5000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mc_ready_in = 1'b1;
    mc_data_in  = 32'hDEAD_BEEF;
    tick();
    mc_ready_in = 1'b0;
    chk_all_zero("t6");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t6_no_req%0d", k), 32'(mc_request_out), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive passed-over grants after which a pending fetch wins arbitration.
REQ-002 clk  in  1  clock; one clock, all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 io_buffer_full  in  1  high: stores with address[17:16]==2'b11 are not issued.
REQ-005 rob_rollback_in  in  1  flush of speculative fetch/load traffic.
REQ-006 fet_request_in / fet_address_in  in  1/32  fetch request pulse, word address.
REQ-007 fet_ready_out / fet_instruction_out  out  1/32  fetch completion pulse and data.
REQ-008 lsb_request_in / lsb_rw_signal_in / lsb_address_in / lsb_goal_in / lsb_data_in  in  1/1/32/3/32  load (rw=0) or store (rw=1) pulse; goal 1/2/4 bytes.
REQ-009 lsb_ready_out / lsb_data_out  out  1/32  load/store completion pulse and load data.
REQ-010 mc_request_out / mc_rw_out / mc_address_out / mc_goal_out / mc_data_out  out  1/1/32/3/32  single-outstanding request to memory controller.
REQ-011 mc_ready_in / mc_data_in  in  1/32  memory controller completion pulse and read data.

Function
REQ-012 Each input request pulse SHALL be latched into a per-class pending slot (fetch, load, store) with its fields.
REQ-013 A request arriving while its class slot is pending or in flight SHALL be ignored.
REQ-014 States SHALL be IDLE and WAIT; at most one request outstanding to mc_* at any time.
REQ-015 In IDLE with an eligible pending slot, the arbiter SHALL clear that slot, drive mc_request_out high for exactly one cycle with its fields, and enter WAIT.
REQ-016 Priority SHALL be: fetch if fetch_skip==STARVE_LIMIT; else eligible store; else load; else fetch.
REQ-017 A store is eligible unless address[17:16]==2'b11 and io_buffer_full is high; an ineligible store SHALL NOT block load or fetch.
REQ-018 fetch_skip (3-bit) SHALL increment on each load/store grant while fetch is pending, saturate at STARVE_LIMIT, and clear on fetch grant.
REQ-019 Fetch grants SHALL use mc_goal_out=4, mc_rw_out=0; load rw=0; store rw=1 with lsb_data_in.
REQ-020 Latency: request pulse in cycle t with arbiter IDLE and no competitor SHALL produce mc_request_out in cycle t+2.
REQ-021 In WAIT, mc_ready_in in cycle u SHALL produce the owning client's ready pulse plus mc_data_in in cycle u+1 and return to IDLE in u+1; next mc_request_out no earlier than u+2.
REQ-022 Store completion SHALL pulse lsb_ready_out; lsb_data_out is don't-care for stores.
REQ-023 On rob_rollback_in, pending fetch and load slots SHALL clear; pending store SHALL be retained.
REQ-024 Rollback while WAIT owns a fetch or load SHALL return to IDLE next cycle with no ready pulse (memory controller aborts same cycle).
REQ-025 Rollback while WAIT owns a store SHALL NOT affect it.
REQ-026 Store request coincident with rollback SHALL be accepted; fetch/load requests coincident with rollback SHALL be dropped.
REQ-027 mc_ready_in coincident with rollback for a fetch/load SHALL be discarded.
REQ-028 mc_ready_in while IDLE SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE, clear all pending slots, fetch_skip=0, all *_ready_out and mc_request_out=0, mc_rw_out=0, all address/data/goal outputs=0.
REQ-030 rst SHALL take precedence over rollback and requests, including mid-WAIT; a later mc_ready_in is ignored.

Verification
REQ-031 Fetch 0x0000_1000 alone -> mc_request_out at t+2, goal 4, rw 0; mc_ready_in with 0x0000_0013 -> fet_ready_out next cycle with 0x0000_0013.
REQ-032 Fetch, load 0x100 and store 0x200 pulsed same cycle -> grant order store, load, fetch.
REQ-033 STARVE_LIMIT=4, fetch pending, 5 load/store pairs streamed -> fetch granted after 4th non-fetch grant.
REQ-034 Store 0x30000, io_buffer_full=1, load pending -> load issued first; store issued only after io_buffer_full drops.
REQ-035 Rollback during WAIT on load, store pending -> no lsb_ready_out for load, IDLE next cycle, store issued next.
REQ-036 rst asserted mid-WAIT then mc_ready_in -> all outputs 0, no ready pulse, no subsequent request.
